// File: rtl/mult_hilo_unit_if.sv
// rtl/mult_hilo_unit_if.sv - decode/EXE handshake bundle for the HI/LO multiply unit
interface mult_hilo_unit_if;
    logic        mult_start;
    logic        mult_signed;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_cancel;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] mt_data;
    logic        mult_ready;
    logic        mult_busy;
    logic        mult_done;
    logic [63:0] product;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output mult_start, mult_signed, mult_a, mult_b, mult_cancel,
               mthi_we, mtlo_we, mt_data,
        input  mult_ready, mult_busy, mult_done, product, hi_out, lo_out
    );

    modport slave (
        input  mult_start, mult_signed, mult_a, mult_b, mult_cancel,
               mthi_we, mtlo_we, mt_data,
        output mult_ready, mult_busy, mult_done, product, hi_out, lo_out
    );
endinterface

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - iterative shift-add 32x32 multiplier owning the HI/LO registers
module mult_hilo_unit (
    input  logic              clk,
    input  logic              rst,
    mult_hilo_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic        neg;
    logic [63:0] prod_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] acc_next;
    logic [63:0] acc_final;
    logic        commit;

    always_comb begin
        abs_a     = (bus.mult_signed && bus.mult_a[31]) ? (~bus.mult_a + 32'd1) : bus.mult_a;
        abs_b     = (bus.mult_signed && bus.mult_b[31]) ? (~bus.mult_b + 32'd1) : bus.mult_b;
        acc_next  = mplier[0] ? (acc + mcand) : acc;
        acc_final = neg ? (~acc_next + 64'd1) : acc_next;
        commit    = (state == DONE) && !bus.mult_cancel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mult_start && !bus.mult_cancel) begin
                        mcand  <= {32'd0, abs_a};
                        mplier <= abs_b;
                        neg    <= bus.mult_signed & (bus.mult_a[31] ^ bus.mult_b[31]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (bus.mult_cancel) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 6'd1;
                        // Last of 32 steps: sign-correct now so DONE presents a registered product.
                        if (cnt == 6'd31) begin
                            prod_q <= acc_final;
                            state  <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // A committing DONE overrides any coincident mthi/mtlo for both halves.
            if (commit) begin
                hi_q <= prod_q[63:32];
                lo_q <= prod_q[31:0];
            end else begin
                if (bus.mthi_we) hi_q <= bus.mt_data;
                if (bus.mtlo_we) lo_q <= bus.mt_data;
            end
        end
    end

    assign bus.mult_ready = (state == IDLE);
    assign bus.mult_busy  = (state != IDLE);
    assign bus.mult_done  = commit;
    assign bus.product    = prod_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mult_hilo_unit_if bus ();
    mult_hilo_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: an accepted operation is tracked only by its age in cycles.
    logic        m_valid = 1'b0;
    logic        m_busy;
    int          m_age;
    logic [63:0] m_prod;
    logic [31:0] m_hi, m_lo;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_age   = 0;
            m_hi    = '0;
            m_lo    = '0;
        end else if (m_valid) begin
            logic wrote;
            wrote = 1'b0;
            if (m_busy) begin
                if (bus.mult_cancel) m_busy = 1'b0;
                else if (m_age == 33) begin
                    m_busy = 1'b0;
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                    wrote  = 1'b1;
                end else m_age++;
            end else if (bus.mult_start && !bus.mult_cancel) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_prod = ref_mul(bus.mult_a, bus.mult_b, bus.mult_signed);
            end
            if (!wrote && bus.mthi_we) m_hi = bus.mt_data;
            if (!wrote && bus.mtlo_we) m_lo = bus.mt_data;
        end
    end

    always @(negedge clk) begin
        if (m_valid && !rst) begin
            logic exp_done;
            exp_done = m_busy && (m_age == 33) && !bus.mult_cancel;
            checks++;
            if (bus.mult_ready !== !m_busy || bus.mult_busy !== m_busy) begin
                errors++;
                $display("FAIL model_busy t=%0t ready=%b busy=%b required busy=%b", $time, bus.mult_ready, bus.mult_busy, m_busy);
            end
            checks++;
            if (bus.mult_done !== exp_done) begin
                errors++;
                $display("FAIL model_done t=%0t got=%b required=%b", $time, bus.mult_done, exp_done);
            end
            if (exp_done) begin
                checks++;
                if (bus.product !== m_prod) begin
                    errors++;
                    $display("FAIL model_product t=%0t got=%h required=%h", $time, bus.product, m_prod);
                end
            end
            checks++;
            if (bus.hi_out !== m_hi || bus.lo_out !== m_lo) begin
                errors++;
                $display("FAIL model_hilo t=%0t got=%h_%h required=%h_%h", $time, bus.hi_out, bus.lo_out, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        bus.mult_start = 1'b1; bus.mult_a = a; bus.mult_b = b; bus.mult_signed = s;
        @(posedge clk); #1;
        bus.mult_start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        int busy_cnt, done_cnt;
        logic [63:0] prod;
        busy_cnt = 0; done_cnt = 0; prod = '0;
        start_op(a, b, s);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mult_busy) busy_cnt++;
            if (bus.mult_done) begin done_cnt++; prod = bus.product; end
        end
        chk({name, "_product"}, prod, exp);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_hilo"}, {bus.hi_out, bus.lo_out}, exp);
    endtask

    initial begin
        int done_cnt, d1;
        logic [63:0] p1, p2;
        logic busy_hist [0:99];
        bus.mult_start = 0; bus.mult_signed = 0; bus.mult_a = 0; bus.mult_b = 0;
        bus.mult_cancel = 0; bus.mthi_we = 0; bus.mtlo_we = 0; bus.mt_data = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_busy_done", {bus.mult_ready, bus.mult_busy, bus.mult_done}, 64'b100);
        chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        chk("model_pin_signed", ref_mul(32'h8000_0000, 32'd2, 1'b1), 64'hFFFF_FFFF_0000_0000);

        run_op("multu_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run_op("mult_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        run_op("mult_min_x2", 32'h8000_0000, 32'd2, 1'b1, 64'hFFFF_FFFF_0000_0000);
        run_op("multu_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);

        // Cancel during CALC cycle 10.
        start_op(32'd7, 32'd9, 1'b0);
        repeat (8) @(posedge clk);
        #1 bus.mult_cancel = 1'b1;
        @(posedge clk); #1 bus.mult_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_ready", 64'(bus.mult_ready), 64'd1);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mult_done) done_cnt++;
        end
        chk("cancel_no_done", 64'(done_cnt), 64'd0);
        chk("cancel_hilo_kept", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);

        // Start while busy is ignored.
        start_op(32'd6, 32'd7, 1'b0);
        done_cnt = 0; p1 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.mult_start = (i >= 5 && i < 15);
            bus.mult_a = 32'd100; bus.mult_b = 32'd100;
            if (bus.mult_done) begin done_cnt++; p1 = bus.product; end
        end
        chk("busy_start_done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_start_product", p1, 64'd42);

        // mtlo colliding with DONE, then mthi while idle.
        start_op(32'd2, 32'd3, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            @(negedge clk);
            if (bus.mult_done) done_cnt++;
        end
        chk("collide_done_seen", 64'(done_cnt), 64'd1);
        bus.mtlo_we = 1'b1; bus.mt_data = 32'h0000_1234;
        @(posedge clk); #1 bus.mtlo_we = 1'b0;
        @(negedge clk);
        chk("collide_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0000_0000_0006);
        @(posedge clk); #1 bus.mthi_we = 1'b1; bus.mt_data = 32'hAAAA_5555;
        @(posedge clk); #1 bus.mthi_we = 1'b0;
        @(negedge clk);
        chk("mthi_idle", 64'(bus.hi_out), 64'h0000_0000_AAAA_5555);

        // Reset during CALC cycle 20.
        start_op(32'd7, 32'd9, 1'b0);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(bus.mult_ready), 64'd1);
        chk("rst_mid_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mult_done) done_cnt++;
        end
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        run_op("multu_2p16_sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);

        // Back-to-back with start held high.
        @(posedge clk); #1;
        bus.mult_start = 1'b1; bus.mult_a = 32'd11; bus.mult_b = 32'd13; bus.mult_signed = 1'b0;
        @(posedge clk); #1;
        bus.mult_a = 32'hFFFF_FFFB; bus.mult_b = 32'd4; bus.mult_signed = 1'b1;
        done_cnt = 0; d1 = 0; p1 = '0; p2 = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            busy_hist[i] = bus.mult_busy;
            if (bus.mult_done) begin
                done_cnt++;
                if (done_cnt == 1) begin d1 = i; p1 = bus.product; end
                else p2 = bus.product;
            end
            if (done_cnt == 1 && i == d1 + 2) bus.mult_start = 1'b0;
        end
        bus.mult_start = 1'b0;
        chk("b2b_done_pulses", 64'(done_cnt), 64'd2);
        chk("b2b_first_product", p1, 64'd143);
        chk("b2b_second_product", p2, 64'hFFFF_FFFF_FFFF_FFEC);
        chk("b2b_idle_gap", 64'(busy_hist[(d1 + 1) % 100]), 64'd0);
        chk("b2b_reaccept", 64'(busy_hist[(d1 + 2) % 100]), 64'd1);
        chk("b2b_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
